// File: rtl/sc_chain_loader.sv
// Feeds the sc_dff_compact configuration chain: accepts words over valid/ready and
// shifts exactly CHAIN_LEN bits LSB-first. Optional word parity check: SC_CHAIN_LOADER_PARITY_EN.
module sc_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              sc_head,
    output logic              sc_shift_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count
`ifdef SC_CHAIN_LOADER_PARITY_EN
    ,
    input  logic              cfg_par,
    output logic              par_err
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] WORD_W_C    = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] ONE_C       = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    logic [WORD_W-1:0]   shreg_r;
    logic [CNT_W-1:0]    word_left_r;
    logic [CNT_W-1:0]    bit_count_r;
    logic                cfg_ready_r;
    logic                sc_head_r;
    logic                sc_shift_en_r;
    logic                busy_r;
    logic                done_r;
    logic [CNT_W-1:0]    remaining_s;
    logic [CNT_W-1:0]    word_take_s;
    logic                last_bit_s;
    logic                par_bad_s;

`ifdef SC_CHAIN_LOADER_PARITY_EN
    logic                par_err_r;

    function automatic logic even_parity(input logic [WORD_W-1:0] d);
        return ^d;
    endfunction
`endif

    // The last word may be partial: only the bits still owed to the chain are shifted.
    always_comb begin
        remaining_s = CHAIN_LEN_C - bit_count_r;
        if (remaining_s < WORD_W_C) begin
            word_take_s = remaining_s;
        end else begin
            word_take_s = WORD_W_C;
        end
        last_bit_s = ((bit_count_r + ONE_C) == CHAIN_LEN_C);
`ifdef SC_CHAIN_LOADER_PARITY_EN
        if (even_parity(cfg_data) != cfg_par) begin
            par_bad_s = 1'b1;
        end else begin
            par_bad_s = 1'b0;
        end
`else
        par_bad_s = 1'b0;
`endif
    end

    // Load FSM; every output is a flop so the chain sees glitch-free head/enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            shreg_r       <= '0;
            word_left_r   <= '0;
            bit_count_r   <= '0;
            cfg_ready_r   <= 1'b0;
            sc_head_r     <= 1'b0;
            sc_shift_en_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
`ifdef SC_CHAIN_LOADER_PARITY_EN
            par_err_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done_r        <= 1'b0;
                    sc_head_r     <= 1'b0;
                    sc_shift_en_r <= 1'b0;
                    if (start) begin
                        state_r     <= LOAD;
                        cfg_ready_r <= 1'b1;
                        busy_r      <= 1'b1;
                        bit_count_r <= '0;
`ifdef SC_CHAIN_LOADER_PARITY_EN
                        par_err_r   <= 1'b0;
`endif
                    end else begin
                        cfg_ready_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                LOAD: begin
                    if (cfg_valid && cfg_ready_r) begin
                        cfg_ready_r <= 1'b0;
                        if (par_bad_s) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
`ifdef SC_CHAIN_LOADER_PARITY_EN
                            par_err_r <= 1'b1;
`endif
                        end else begin
                            state_r       <= SHIFT;
                            sc_head_r     <= cfg_data[0];
                            shreg_r       <= cfg_data >> 1'b1;
                            sc_shift_en_r <= 1'b1;
                            word_left_r   <= word_take_s;
                        end
                    end else begin
                        cfg_ready_r <= 1'b1;
                    end
                end
                SHIFT: begin
                    // The chain samples sc_head on every edge of this state.
                    bit_count_r <= bit_count_r + ONE_C;
                    word_left_r <= word_left_r - ONE_C;
                    if (word_left_r == ONE_C) begin
                        sc_shift_en_r <= 1'b0;
                        sc_head_r     <= 1'b0;
                        if (last_bit_s) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r     <= LOAD;
                            cfg_ready_r <= 1'b1;
                        end
                    end else begin
                        sc_head_r <= shreg_r[0];
                        shreg_r   <= shreg_r >> 1'b1;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r       <= IDLE;
                    cfg_ready_r   <= 1'b0;
                    sc_head_r     <= 1'b0;
                    sc_shift_en_r <= 1'b0;
                    busy_r        <= 1'b0;
                    done_r        <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready   = cfg_ready_r;
    assign sc_head     = sc_head_r;
    assign sc_shift_en = sc_shift_en_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign bit_count   = bit_count_r;
`ifdef SC_CHAIN_LOADER_PARITY_EN
    assign par_err     = par_err_r;
`endif

endmodule

// File: tb/tb_sc_chain_loader.sv
// Self-checking bench for sc_chain_loader: a 20-bit chain instance (3 words of 8/8/4) and an
// 8-bit chain instance, checked against a bit-stream / cycle-count model and a chain shift model.
module tb_sc_chain_loader;
    localparam int CL = 20;

    logic        clk = 1'b0;
    logic        reset_n, start, cfg_valid, cfg_ready, sc_head, sc_shift_en, busy, done;
    logic [7:0]  cfg_data;
    logic [15:0] bit_count;
    logic        start8, valid8, ready8, head8, en8, busy8, done8;
    logic [7:0]  data8;
    logic [15:0] count8;
`ifdef SC_CHAIN_LOADER_PARITY_EN
    logic        cfg_par, par_err, par_err8;
`endif

    always #5 clk = ~clk;

    sc_chain_loader #(.WORD_W(8), .CHAIN_LEN(CL), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .sc_head(sc_head), .sc_shift_en(sc_shift_en), .busy(busy),
        .done(done), .bit_count(bit_count)
`ifdef SC_CHAIN_LOADER_PARITY_EN
        , .cfg_par(cfg_par), .par_err(par_err)
`endif
    );

    sc_chain_loader #(.WORD_W(8), .CHAIN_LEN(8), .CNT_W(16)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .cfg_data(data8), .cfg_valid(valid8),
        .cfg_ready(ready8), .sc_head(head8), .sc_shift_en(en8), .busy(busy8),
        .done(done8), .bit_count(count8)
`ifdef SC_CHAIN_LOADER_PARITY_EN
        , .cfg_par(^data8), .par_err(par_err8)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Observation of what the chain actually sees (sampled mid-cycle).
    int          pulses = 0, done_cnt = 0, done_cyc = 0, head_viol = 0, run_len = 0;
    logic        stream[$];
    int          runs[$];
    logic [CL-1:0] chain = '0;
    int          pulses8 = 0, last_pulse8 = 0, done_cnt8 = 0, done_cyc8 = 0;

    // Reference model inputs: three words and the valid gap before each.
    logic [7:0]  mw[3];
    int          mg[3];
    int          p0, s0, r0, d0, h0, es;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sc_shift_en === 1'b1) begin
            pulses  <= pulses + 1;
            stream.push_back(sc_head);
            chain   <= {chain[CL-2:0], sc_head};
            run_len <= run_len + 1;
        end else begin
            if (run_len != 0) runs.push_back(run_len);
            run_len <= 0;
            if (sc_head !== 1'b0) head_viol <= head_viol + 1;
        end
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (en8 === 1'b1) begin
            pulses8     <= pulses8 + 1;
            last_pulse8 <= cyc;
        end
        if (done8 === 1'b1) begin
            done_cnt8 <= done_cnt8 + 1;
            done_cyc8 <= cyc;
        end
    end

    function automatic int word_bits(int k);
        return ((CL - 8 * k) < 8) ? (CL - 8 * k) : 8;
    endfunction

    function automatic int model_cycles();
        int t = 0;
        for (int k = 0; k < 3; k++) t += 1 + mg[k] + word_bits(k);
        return t;
    endfunction

    function automatic logic model_bit(int i);
        logic [7:0] w;
        w = mw[i / 8];
        return w[i % 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        p0 = pulses; s0 = stream.size(); r0 = runs.size(); d0 = done_cnt; h0 = head_viol;
    endtask

    task automatic rand_words();
        for (int k = 0; k < 3; k++) begin
            mw[k] = 8'($urandom_range(0, 255));
            mg[k] = 0;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        es = cyc;
        checks++;
        if (busy !== 1'b1 || cfg_ready !== 1'b1 || bit_count !== 16'd0) begin
            errors++;
            $display("FAIL start_enter: busy=%b ready=%b count=%0d, want 1 1 0", busy, cfg_ready, bit_count);
        end
    endtask

    task automatic send_word(input logic [7:0] d, input int gap, input bit bad_par);
        int n = 0;
        cfg_valid = 1'b0;
        while (cfg_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: cfg_ready=%b after %0d cycles, want 1", cfg_ready, n);
        end
        for (int g = 0; g < gap; g++) begin
            checks++;
            if (cfg_ready !== 1'b1 || sc_shift_en !== 1'b0) begin
                errors++;
                $display("FAIL gap_hold: ready=%b shift_en=%b, want 1 0", cfg_ready, sc_shift_en);
            end
            tick();
        end
        cfg_valid = 1'b1;
        cfg_data  = d;
`ifdef SC_CHAIN_LOADER_PARITY_EN
        cfg_par   = bad_par ? ~(^d) : (^d);
`else
        if (bad_par) cfg_data = d;
`endif
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic drive_load();
        for (int k = 0; k < 3; k++) send_word(mw[k], mg[k], 1'b0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: done=%b after %0d cycles, want 1", done, n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({cfg_ready, sc_head, sc_shift_en, busy, done} !== 5'b0 || bit_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b count=%0d, want 00000 0",
                     {cfg_ready, sc_head, sc_shift_en, busy, done}, bit_count);
        end
        reset_n = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b0 || ready8 !== 1'b0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b ready=%b ready8=%b busy8=%b, want 0",
                     busy, cfg_ready, ready8, busy8);
        end
    endtask

    task automatic test_basic_load();
        int bad_s = 0, bad_c = 0;
        mw[0] = 8'hA5; mw[1] = 8'h3C; mw[2] = 8'h0F;
        mg[0] = 0; mg[1] = 0; mg[2] = 0;
        snap();
        do_start();
        drive_load();
        wait_done();
        checks++;
        if (bit_count !== 16'd20 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_state: count=%0d busy=%b, want 20 0", bit_count, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width: done=%b one cycle later, want 0", done);
        end
        tick();
        checks++;
        if (pulses - p0 !== 20 || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL basic_counts: pulses=%0d dones=%0d, want 20 1", pulses - p0, done_cnt - d0);
        end
        checks++;
        if (done_cyc - es !== model_cycles()) begin
            errors++;
            $display("FAIL basic_latency: %0d cycles, want %0d", done_cyc - es, model_cycles());
        end
        checks++;
        if (runs.size() - r0 !== 3 || runs[r0] !== 8 || runs[r0+1] !== 8 || runs[r0+2] !== 4) begin
            errors++;
            $display("FAIL basic_runs: %0d runs, first=%0d, want 3 runs 8/8/4", runs.size() - r0, runs[r0]);
        end
        for (int i = 0; i < CL; i++) begin
            if (stream[s0+i] !== model_bit(i)) bad_s++;
            if (chain[CL-1-i] !== model_bit(i)) bad_c++;
        end
        checks++;
        if (bad_s != 0) begin
            errors++;
            $display("FAIL basic_stream: %0d wrong bits, want 0", bad_s);
        end
        checks++;
        if (bad_c != 0) begin
            errors++;
            $display("FAIL basic_chain: chain=%h with %0d wrong cells, want 0", chain, bad_c);
        end
        checks++;
        if (head_viol - h0 !== 0) begin
            errors++;
            $display("FAIL head_idle: %0d cycles with head=1 and shift_en=0, want 0", head_viol - h0);
        end
    endtask

    task automatic test_valid_gap();
        int bad_s = 0;
        mw[0] = 8'hA5; mw[1] = 8'h3C; mw[2] = 8'h0F;
        mg[0] = 0; mg[1] = 5; mg[2] = 0;
        snap();
        do_start();
        drive_load();
        wait_done();
        tick();
        tick();
        for (int i = 0; i < CL; i++) if (stream[s0+i] !== model_bit(i)) bad_s++;
        checks++;
        if (bad_s != 0 || pulses - p0 !== 20) begin
            errors++;
            $display("FAIL gap_stream: %0d wrong bits, %0d pulses, want 0 and 20", bad_s, pulses - p0);
        end
        checks++;
        if (done_cyc - es !== model_cycles()) begin
            errors++;
            $display("FAIL gap_latency: %0d cycles, want %0d", done_cyc - es, model_cycles());
        end
    endtask

    task automatic test_start_ignored();
        rand_words();
        snap();
        do_start();
        send_word(mw[0], 0, 1'b0);
        send_word(mw[1], 0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (bit_count !== 16'd9 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_mid_shift: count=%0d busy=%b, want 9 1", bit_count, busy);
        end
        send_word(mw[2], 0, 1'b0);
        wait_done();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b0 || bit_count !== 16'd20) begin
            errors++;
            $display("FAIL start_in_done: busy=%b ready=%b count=%0d, want 0 0 20", busy, cfg_ready, bit_count);
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || pulses - p0 !== 20 || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL start_ignored_totals: busy=%b pulses=%0d dones=%0d, want 0 20 1",
                     busy, pulses - p0, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_shift();
        int bad_s = 0;
        rand_words();
        do_start();
        send_word(mw[0], 0, 1'b0);
        send_word(mw[1], 0, 1'b0);
        tick();
        tick();
        checks++;
        if (sc_shift_en !== 1'b1 || bit_count !== 16'd10) begin
            errors++;
            $display("FAIL pre_reset: shift_en=%b count=%0d, want 1 10", sc_shift_en, bit_count);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (sc_shift_en !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b0 || bit_count !== 16'd0 || sc_head !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: shift_en=%b busy=%b ready=%b count=%0d head=%b, want all 0",
                     sc_shift_en, busy, cfg_ready, bit_count, sc_head);
        end
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        rand_words();
        snap();
        do_start();
        drive_load();
        wait_done();
        tick();
        tick();
        for (int i = 0; i < CL; i++) if (stream[s0+i] !== model_bit(i)) bad_s++;
        checks++;
        if (bad_s != 0 || pulses - p0 !== 20 || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL reload_after_reset: %0d bad bits, pulses=%0d dones=%0d, want 0 20 1",
                     bad_s, pulses - p0, done_cnt - d0);
        end
    endtask

    task automatic test_single_word();
        int n = 0;
        int b0 = pulses8, bd = done_cnt8;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        valid8 = 1'b1;
        data8  = 8'hFF;
        tick();
        data8  = 8'h5A;
        while (done8 !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (done8 !== 1'b1 || count8 !== 16'd8) begin
            errors++;
            $display("FAIL single_done: done8=%b count8=%0d, want 1 8", done8, count8);
        end
        tick();
        tick();
        tick();
        checks++;
        if (ready8 !== 1'b0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL single_no_accept: ready8=%b busy8=%b, want 0 0", ready8, busy8);
        end
        checks++;
        if (pulses8 - b0 !== 8 || done_cnt8 - bd !== 1 || done_cyc8 !== last_pulse8 + 1) begin
            errors++;
            $display("FAIL single_counts: pulses=%0d dones=%0d done_cyc=%0d last_pulse=%0d, want 8 1 and +1",
                     pulses8 - b0, done_cnt8 - bd, done_cyc8, last_pulse8);
        end
        valid8 = 1'b0;
    endtask

    task automatic test_random_loads();
        for (int it = 0; it < 4; it++) begin
            int bad_s = 0;
            rand_words();
            for (int k = 0; k < 3; k++) mg[k] = $urandom_range(0, 3);
            snap();
            do_start();
            drive_load();
            wait_done();
            tick();
            tick();
            for (int i = 0; i < CL; i++) if (stream[s0+i] !== model_bit(i)) bad_s++;
            checks++;
            if (bad_s != 0 || pulses - p0 !== 20) begin
                errors++;
                $display("FAIL random_stream[%0d]: %0d bad bits, %0d pulses, want 0 20", it, bad_s, pulses - p0);
            end
            checks++;
            if (done_cyc - es !== model_cycles()) begin
                errors++;
                $display("FAIL random_latency[%0d]: %0d cycles, want %0d", it, done_cyc - es, model_cycles());
            end
        end
    endtask

`ifdef SC_CHAIN_LOADER_PARITY_EN
    task automatic test_parity();
        rand_words();
        snap();
        do_start();
        send_word(mw[0], 0, 1'b0);
        send_word(mw[1], 0, 1'b1);
        wait_done();
        checks++;
        if (par_err !== 1'b1 || bit_count !== 16'd8) begin
            errors++;
            $display("FAIL parity_abort: par_err=%b count=%0d, want 1 8", par_err, bit_count);
        end
        tick();
        tick();
        checks++;
        if (pulses - p0 !== 8 || done_cnt - d0 !== 1 || par_err !== 1'b1) begin
            errors++;
            $display("FAIL parity_totals: pulses=%0d dones=%0d par_err=%b, want 8 1 1",
                     pulses - p0, done_cnt - d0, par_err);
        end
        do_start();
        checks++;
        if (par_err !== 1'b0) begin
            errors++;
            $display("FAIL parity_clear: par_err=%b after start, want 0", par_err);
        end
        drive_load();
        wait_done();
        tick();
    endtask
`endif

    initial begin
        start = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
        start8 = 1'b0; valid8 = 1'b0; data8 = 8'h00;
`ifdef SC_CHAIN_LOADER_PARITY_EN
        cfg_par = 1'b0;
`endif
        test_reset();
        test_basic_load();
        test_valid_gap();
        test_start_ignored();
        test_reset_mid_shift();
        test_single_word();
        test_random_loads();
`ifdef SC_CHAIN_LOADER_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
